// File: rtl/dsr_align_seq_if.sv
// Control/status bundle between the ADC deserializer alignment sequencer and
// its environment.
//   start, abort : pass request / immediate return to idle
//   aligned      : per-segment alignment-FSM locked flags (clk domain)
//   pat_match    : per-segment training-pattern match flags (clk domain)
//   seg_rst      : one-hot per-segment deserializer reset pulse
//   seg_idx      : segment currently being processed
//   busy, done   : sequencer status
//   fail_mask    : segments that exhausted their retries
//   retry_cnt    : attempts already used on the current segment
interface dsr_align_seq_if #(
   parameter int unsigned NSEG = 12
);
   logic            start;
   logic            abort;
   logic [NSEG-1:0] aligned;
   logic [NSEG-1:0] pat_match;
   logic [NSEG-1:0] seg_rst;
   logic [3:0]      seg_idx;
   logic            busy;
   logic            done;
   logic [NSEG-1:0] fail_mask;
   logic [1:0]      retry_cnt;

   modport master (
      output start, abort, aligned, pat_match,
      input  seg_rst, seg_idx, busy, done, fail_mask, retry_cnt
   );

   modport slave (
      input  start, abort, aligned, pat_match,
      output seg_rst, seg_idx, busy, done, fail_mask, retry_cnt
   );
endinterface

// File: rtl/dsr_align_seq.sv
// Sequencer that resets and re-aligns each ADC deserializer segment in turn,
// qualifying every segment with a run of training-pattern matches and
// retrying a bounded number of times before marking it failed.
//   clk, rst_n : sequencing clock, asynchronous active-low reset
//   bus        : dsr_align_seq_if.slave (start/abort/aligned/pat_match in;
//                seg_rst/seg_idx/busy/done/fail_mask/retry_cnt out, all registered)
module dsr_align_seq #(
   parameter int unsigned NSEG      = 12,
   parameter int unsigned RST_CYC   = 4,
   parameter int unsigned TMO_CYC   = 1023,
   parameter int unsigned CHK_CYC   = 8,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   dsr_align_seq_if.slave  bus
);

   localparam int unsigned RW = $clog2(RST_CYC + 1);
   localparam int unsigned WW = $clog2(TMO_CYC + 1);
   localparam int unsigned MW = $clog2(CHK_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SRST, S_WAIT_ALGN, S_CHECK, S_NEXT, S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [RW-1:0]   rst_cnt_q, rst_cnt_d;
   logic [WW-1:0]   wait_cnt_q, wait_cnt_d;
   logic [MW-1:0]   match_cnt_q, match_cnt_d;
   logic [3:0]      seg_idx_q, seg_idx_d;
   logic [1:0]      retry_q, retry_d;
   logic [NSEG-1:0] fail_q, fail_d;
   logic [NSEG-1:0] seg_rst_q, seg_rst_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            aligned_cur;
   logic            match_cur;
   logic            retry_req;

   assign aligned_cur = bus.aligned[seg_idx_q];
   assign match_cur   = bus.pat_match[seg_idx_q];

   // State, datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         rst_cnt_q   <= '0;
         wait_cnt_q  <= '0;
         match_cnt_q <= '0;
         seg_idx_q   <= '0;
         retry_q     <= '0;
         fail_q      <= '0;
         seg_rst_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rst_cnt_q   <= rst_cnt_d;
         wait_cnt_q  <= wait_cnt_d;
         match_cnt_q <= match_cnt_d;
         seg_idx_q   <= seg_idx_d;
         retry_q     <= retry_d;
         fail_q      <= fail_d;
         seg_rst_q   <= seg_rst_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   // Next state and counter updates; abort overrides everything and freezes the datapath
   always_comb begin
      state_d     = state_q;
      rst_cnt_d   = rst_cnt_q;
      wait_cnt_d  = wait_cnt_q;
      match_cnt_d = match_cnt_q;
      seg_idx_d   = seg_idx_q;
      retry_d     = retry_q;
      fail_d      = fail_q;
      retry_req   = 1'b0;

      if (bus.abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  state_d   = S_SRST;
                  seg_idx_d = '0;
                  retry_d   = '0;
                  fail_d    = '0;
                  rst_cnt_d = '0;
               end
            end
            S_SRST: begin
               if (rst_cnt_q == RW'(RST_CYC - 1)) begin
                  state_d    = S_WAIT_ALGN;
                  wait_cnt_d = '0;
               end else begin
                  rst_cnt_d = rst_cnt_q + RW'(1);
               end
            end
            S_WAIT_ALGN: begin
               if (aligned_cur) begin
                  state_d     = S_CHECK;
                  match_cnt_d = '0;
               end else if (wait_cnt_q == WW'(TMO_CYC)) begin
                  retry_req = 1'b1;
               end else begin
                  wait_cnt_d = wait_cnt_q + WW'(1);
               end
            end
            S_CHECK: begin
               if (!aligned_cur) begin
                  retry_req = 1'b1;
               end else if (match_cur) begin
                  if (match_cnt_q != MW'(CHK_CYC)) begin
                     match_cnt_d = match_cnt_q + MW'(1);
                  end
                  if (match_cnt_q == MW'(CHK_CYC - 1)) begin
                     state_d = S_NEXT;
                  end
               end else begin
                  match_cnt_d = '0;
               end
            end
            S_NEXT: begin
               if (seg_idx_q == 4'(NSEG - 1)) begin
                  state_d = S_DONE;
               end else begin
                  state_d   = S_SRST;
                  seg_idx_d = seg_idx_q + 4'd1;
                  retry_d   = '0;
                  rst_cnt_d = '0;
               end
            end
            default: state_d = S_IDLE;
         endcase

         // Timeout or lost alignment: re-reset the segment or give up on it
         if (retry_req) begin
            if (retry_q < 2'(MAX_RETRY - 1)) begin
               state_d   = S_SRST;
               retry_d   = retry_q + 2'd1;
               rst_cnt_d = '0;
            end else begin
               state_d             = S_NEXT;
               fail_d[seg_idx_q]   = 1'b1;
            end
         end
      end
   end

   // Output decode from the next state so the registered outputs track the state register
   always_comb begin
      seg_rst_d = '0;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      case (state_d)
         S_IDLE: ;
         S_DONE: done_d = 1'b1;
         S_SRST: begin
            seg_rst_d = NSEG'(1) << seg_idx_d;
            busy_d    = 1'b1;
         end
         default: busy_d = 1'b1;
      endcase
   end

   assign bus.seg_rst   = seg_rst_q;
   assign bus.seg_idx   = seg_idx_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.fail_mask = fail_q;
   assign bus.retry_cnt = retry_q;

endmodule

// File: tb/tb_dsr_align_seq.sv
// Directed bench for dsr_align_seq: clean pass, stuck segment, pattern
// glitches, alignment drop, abort and mid-pass reset.
module tb_dsr_align_seq;

   localparam int unsigned NSEG  = 12;
   localparam int          LIMIT = 6000;
   localparam logic [NSEG-1:0] ALL1 = '1;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_miss;

   dsr_align_seq_if #(.NSEG(NSEG)) bus ();

   dsr_align_seq #(
      .NSEG(NSEG), .RST_CYC(4), .TMO_CYC(1023), .CHK_CYC(8), .MAX_RETRY(3)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point for every check
   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Per-cycle input pattern for each scenario; n = edges since START was taken
   task automatic drive(input int mode, input int n);
      logic [NSEG-1:0] a;
      logic [NSEG-1:0] p;
      a = ALL1;
      p = ALL1;
      case (mode)
         1: a[5] = 1'b0;
         2: p[2] = (n < 60) ? (((n / 4) % 2) == 0) : 1'b1;
         3: if (n == 105) a[7] = 1'b0;
         default: ;
      endcase
      bus.aligned   = a;
      bus.pat_match = p;
   endtask

   // Launch a pass and follow it to DONE, profiling the pulses of segment tseg
   task automatic run_pass(input int mode, input int tseg, output int ncyc, output int npulse,
                           output int nhigh, output int maxr, output int gap, output int bad);
      int   n;
      int   last_rise;
      int   k;
      logic prev;
      logic [NSEG-1:0] exp_rst;
      drive(mode, 0);
      bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
      n = 0; npulse = 0; nhigh = 0; maxr = 0; gap = 0; bad = 0;
      last_rise = -1;
      prev = 1'b0;
      while (!bus.done && n < LIMIT) begin
         if (bus.seg_rst[tseg]) begin
            nhigh++;
            if (!prev) begin
               npulse++;
               if (last_rise >= 0) gap = n - last_rise;
               last_rise = n;
            end
         end
         prev = bus.seg_rst[tseg];
         if (int'(bus.retry_cnt) > maxr) maxr = int'(bus.retry_cnt);
         if ($countones(bus.seg_rst) > 1) bad++;
         if (mode == 0 && n < 168) begin
            k = n / 14;
            exp_rst = ((n % 14) < 4) ? (NSEG'(1) << k) : '0;
            if (bus.seg_rst !== exp_rst || int'(bus.seg_idx) != k) bad++;
         end
         cyc(1);
         n++;
         drive(mode, n);
      end
      ncyc = n;
   endtask

   initial begin
      int ncyc, npulse, nhigh, maxr, gap, bad;
      n_vec = 0;
      n_miss = 0;
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      bus.aligned = '0;
      bus.pat_match = '0;

      // Reset state
      cyc(3);
      check_val("rst_seg_rst", 32'(bus.seg_rst), 32'h0);
      check_val("rst_seg_idx", 32'(bus.seg_idx), 32'h0);
      check_val("rst_busy", 32'(bus.busy), 32'h0);
      check_val("rst_done", 32'(bus.done), 32'h0);
      check_val("rst_fail", 32'(bus.fail_mask), 32'h0);
      check_val("rst_retry", 32'(bus.retry_cnt), 32'h0);
      rst_n = 1'b1;
      cyc(2);
      check_val("idle_busy", 32'(bus.busy), 32'h0);

      // Clean pass: 12 segments x 14 cycles, reset pulses in order
      run_pass(0, 0, ncyc, npulse, nhigh, maxr, gap, bad);
      check_val("clean_cycles", 32'(ncyc), 32'd168);
      check_val("clean_seq", 32'(bad), 32'd0);
      check_val("clean_fail", 32'(bus.fail_mask), 32'h0);
      check_val("clean_busy", 32'(bus.busy), 32'h0);
      cyc(5);
      check_val("done_hold", 32'(bus.done), 32'h1);
      check_val("done_idx", 32'(bus.seg_idx), 32'd11);

      // Segment 5 never aligns: three 1028-cycle attempts, then marked failed
      run_pass(1, 5, ncyc, npulse, nhigh, maxr, gap, bad);
      check_val("stuck_cycles", 32'(ncyc), 32'd3239);
      check_val("stuck_pulses", 32'(npulse), 32'd3);
      check_val("stuck_high", 32'(nhigh), 32'd12);
      check_val("stuck_gap", 32'(gap), 32'd1028);
      check_val("stuck_retry", 32'(maxr), 32'd2);
      check_val("stuck_fail", 32'(bus.fail_mask), 32'h020);
      check_val("stuck_done", 32'(bus.done), 32'h1);
      check_val("stuck_onehot", 32'(bad), 32'd0);

      // Segment 2 pattern toggles: match run restarts, no retry, 23 cycles late
      run_pass(2, 2, ncyc, npulse, nhigh, maxr, gap, bad);
      check_val("glitch_cycles", 32'(ncyc), 32'd191);
      check_val("glitch_pulses", 32'(npulse), 32'd1);
      check_val("glitch_retry", 32'(maxr), 32'd0);
      check_val("glitch_fail", 32'(bus.fail_mask), 32'h0);

      // Segment 7 loses alignment in CHECK once: one retry, then passes
      run_pass(3, 7, ncyc, npulse, nhigh, maxr, gap, bad);
      check_val("drop_cycles", 32'(ncyc), 32'd176);
      check_val("drop_pulses", 32'(npulse), 32'd2);
      check_val("drop_high", 32'(nhigh), 32'd8);
      check_val("drop_gap", 32'(gap), 32'd8);
      check_val("drop_retry", 32'(maxr), 32'd1);
      check_val("drop_fail", 32'(bus.fail_mask), 32'h0);
      check_val("drop_retry_end", 32'(bus.retry_cnt), 32'd0);

      // START while busy is ignored; ABORT in SRST of segment 4 keeps FAIL_MASK
      bus.aligned = 12'hFFE;
      bus.pat_match = ALL1;
      bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
      cyc(20);
      check_val("busy_wait_idx", 32'(bus.seg_idx), 32'd0);
      bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
      check_val("busy_start_rst", 32'(bus.seg_rst), 32'h0);
      check_val("busy_start_busy", 32'(bus.busy), 32'h1);
      cyc(3107);
      check_val("abort_pre_rst", 32'(bus.seg_rst), 32'h010);
      check_val("abort_pre_idx", 32'(bus.seg_idx), 32'd4);
      bus.abort = 1'b1;
      bus.start = 1'b1;
      cyc(1);
      check_val("abort_busy", 32'(bus.busy), 32'h0);
      check_val("abort_rst", 32'(bus.seg_rst), 32'h0);
      check_val("abort_done", 32'(bus.done), 32'h0);
      check_val("abort_fail", 32'(bus.fail_mask), 32'h001);
      cyc(1);
      check_val("abort_prio", 32'(bus.busy), 32'h0);
      bus.abort = 1'b0;
      bus.start = 1'b0;
      cyc(3);
      check_val("abort_idle", 32'(bus.seg_rst), 32'h0);

      // Reset pulse while segment 3 waits for alignment
      bus.aligned = 12'hFF7;
      bus.start = 1'b1;
      cyc(1);
      bus.start = 1'b0;
      cyc(50);
      check_val("mid_idx", 32'(bus.seg_idx), 32'd3);
      check_val("mid_busy", 32'(bus.busy), 32'h1);
      rst_n = 1'b0;
      #2;
      check_val("arst_busy", 32'(bus.busy), 32'h0);
      check_val("arst_idx", 32'(bus.seg_idx), 32'h0);
      check_val("arst_rst", 32'(bus.seg_rst), 32'h0);
      check_val("arst_fail", 32'(bus.fail_mask), 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         cyc(1);
         if (bus.seg_rst != '0 || bus.busy) bad++;
      end
      check_val("no_resume", 32'(bad), 32'd0);
      check_val("post_rst_done", 32'(bus.done), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
